// File: rtl/bus_arbiter.sv
// Two-requester system-bus arbiter: round-robin grant between core and debug,
// one latched transaction at a time, with bus error and timeout reporting.
module bus_arbiter #(
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 core_rd,
   input  logic                 core_wr,
   input  logic [AddrWidth-1:0] core_addr,
   input  logic [DataWidth-1:0] core_wdata,
   input  logic [2:0]           core_size,
   output logic [DataWidth-1:0] core_rdata,
   output logic                 core_done,
   output logic                 core_fault,
   input  logic                 dbg_rd,
   input  logic                 dbg_wr,
   input  logic [AddrWidth-1:0] dbg_addr,
   input  logic [DataWidth-1:0] dbg_wdata,
   input  logic [2:0]           dbg_size,
   output logic [DataWidth-1:0] dbg_rdata,
   output logic                 dbg_done,
   output logic                 dbg_fault,
   output logic                 bus_rd,
   output logic                 bus_wr,
   output logic [AddrWidth-1:0] bus_addr,
   output logic [DataWidth-1:0] bus_wdata,
   output logic [2:0]           bus_size,
   input  logic [DataWidth-1:0] bus_rdata,
   input  logic                 bus_ack,
   input  logic                 bus_err,
   output logic                 owner_dbg
);

   localparam int CntWidth = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 owner_dbg_q, owner_dbg_d;
   logic                 last_dbg_q, last_dbg_d;
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [2:0]           size_q, size_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 fault_q, fault_d;

   logic core_act, dbg_act, grant_dbg;
   logic busy, resp, illegal;

   assign core_act  = core_rd | core_wr;
   assign dbg_act   = dbg_rd | dbg_wr;
   // Debug wins only when alone, or on a tie when core was granted last.
   assign grant_dbg = dbg_act & (~core_act | ~last_dbg_q);
   assign illegal   = rd_q & wr_q;

   always_comb begin
      state_d     = state_q;
      owner_dbg_d = owner_dbg_q;
      last_dbg_d  = last_dbg_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      fault_d     = fault_q;
      case (state_q)
         IDLE: begin
            if (core_act | dbg_act) begin
               owner_dbg_d = grant_dbg;
               last_dbg_d  = grant_dbg;
               rd_d        = grant_dbg ? dbg_rd    : core_rd;
               wr_d        = grant_dbg ? dbg_wr    : core_wr;
               addr_d      = grant_dbg ? dbg_addr  : core_addr;
               wdata_d     = grant_dbg ? dbg_wdata : core_wdata;
               size_d      = grant_dbg ? dbg_size  : core_size;
               cnt_d       = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (illegal || bus_err) begin
               fault_d = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else if (bus_ack) begin
               fault_d = 1'b0;
               rdata_d = wr_q ? '0 : bus_rdata;
               state_d = RESP;
            end else if (cnt_q == CntLast) begin
               fault_d = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_dbg_q <= 1'b0;
         last_dbg_q  <= 1'b1;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_dbg_q <= owner_dbg_d;
         last_dbg_q  <= last_dbg_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         fault_q     <= fault_d;
      end
   end

   // Every output decodes registered state only, so strobes fall the cycle after ack/err.
   assign busy      = (state_q == BUSY);
   assign resp      = (state_q == RESP);
   assign bus_rd    = busy & rd_q & ~wr_q;
   assign bus_wr    = busy & wr_q & ~rd_q;
   assign bus_addr  = busy ? addr_q  : '0;
   assign bus_wdata = busy ? wdata_q : '0;
   assign bus_size  = busy ? size_q  : '0;
   assign owner_dbg = (state_q != IDLE) & owner_dbg_q;

   assign core_done  = resp & ~owner_dbg_q;
   assign core_rdata = core_done ? rdata_q : '0;
   assign core_fault = core_done & fault_q;
   assign dbg_done   = resp & owner_dbg_q;
   assign dbg_rdata  = dbg_done ? rdata_q : '0;
   assign dbg_fault  = dbg_done & fault_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: grant order, bus handshake, faults, reset abort.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_rd = 0, core_wr = 0;
   logic [31:0] core_addr = 0, core_wdata = 0;
   logic [2:0]  core_size = 0;
   logic [31:0] core_rdata;
   logic        core_done, core_fault;
   logic        dbg_rd = 0, dbg_wr = 0;
   logic [31:0] dbg_addr = 0, dbg_wdata = 0;
   logic [2:0]  dbg_size = 0;
   logic [31:0] dbg_rdata;
   logic        dbg_done, dbg_fault;
   logic        bus_rd, bus_wr;
   logic [31:0] bus_addr, bus_wdata;
   logic [2:0]  bus_size;
   logic [31:0] bus_rdata = 0;
   logic        bus_ack = 0, bus_err = 0;
   logic        owner_dbg;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Observations gathered by run()
   int          r_lat, r_strobes;
   logic        r_who, r_own1, r_fault, r_other_bad, r_pulse_bad;
   logic [31:0] r_rdata, r_addr, r_wdata;
   logic [2:0]  r_size;

   bus_arbiter #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(4)) dut (
      .clk(clk), .rst(rst),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_size(core_size),
      .core_rdata(core_rdata), .core_done(core_done), .core_fault(core_fault),
      .dbg_rd(dbg_rd), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_size(dbg_size),
      .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_fault(dbg_fault),
      .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_size(bus_size),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
      .owner_dbg(owner_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] sz);
      core_rd = rd; core_wr = wr; core_addr = a; core_wdata = wd; core_size = sz;
   endtask

   task automatic set_dbg(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] sz);
      dbg_rd = rd; dbg_wr = wr; dbg_addr = a; dbg_wdata = wd; dbg_size = sz;
   endtask

   // Called in IDLE with commands set. Cycle c=1 is the first BUSY cycle; response
   // is presented during BUSY cycle ack_c / err_c (0 = never). Ends back in IDLE.
   task automatic run(input int ack_c, input int err_c, input logic [31:0] rdv);
      bit fin = 0;
      r_lat = 0; r_strobes = 0; r_who = 0; r_own1 = 0; r_fault = 0;
      r_other_bad = 0; r_pulse_bad = 0; r_rdata = 0; r_addr = 0; r_wdata = 0; r_size = 0;
      for (int c = 1; c <= 20 && !fin; c++) begin
         tick();
         bus_ack = 0; bus_err = 0; bus_rdata = 0;
         if (c == 1) begin
            r_own1 = owner_dbg; r_addr = bus_addr; r_wdata = bus_wdata; r_size = bus_size;
         end
         if (bus_rd | bus_wr) r_strobes++;
         if (core_done | dbg_done) begin
            fin = 1; r_lat = c; r_who = dbg_done;
            if (dbg_done) begin
               r_rdata = dbg_rdata; r_fault = dbg_fault;
               r_other_bad = core_done | core_fault | (core_rdata != 0);
               dbg_rd = 0; dbg_wr = 0;
            end else begin
               r_rdata = core_rdata; r_fault = core_fault;
               r_other_bad = dbg_done | dbg_fault | (dbg_rdata != 0);
               core_rd = 0; core_wr = 0;
            end
         end else begin
            if (c == ack_c) begin bus_ack = 1; bus_rdata = rdv; end
            if (c == err_c) begin bus_err = 1; bus_rdata = rdv; end
         end
      end
      tick();
      r_pulse_bad = core_done | dbg_done;
      $display("txn owner=%s addr=%h lat=%0d strobes=%0d rdata=%h fault=%0d",
               r_who ? "dbg" : "core", r_addr, r_lat, r_strobes, r_rdata, r_fault);
   endtask

   task automatic test_reset();
      #2;
      vec_cnt++;
      if ({bus_rd, bus_wr, bus_addr, bus_wdata, bus_size, core_rdata, core_done, core_fault,
           dbg_rdata, dbg_done, dbg_fault, owner_dbg} !== '0) begin
         err_cnt++; $display("FAIL reset_outputs: some output nonzero, bus_addr=%h core_done=%b", bus_addr, core_done);
      end
      tick();
      rst = 0;
      tick();
      vec_cnt++;
      if ({bus_rd, bus_wr, core_done, dbg_done, owner_dbg} !== 5'b0) begin
         err_cnt++; $display("FAIL idle_after_reset: got %b want 00000", {bus_rd, bus_wr, core_done, dbg_done, owner_dbg});
      end
   endtask

   task automatic test_core_read();
      set_core(1, 0, 32'h100, 0, 3'b010);
      run(3, 0, 32'hDEADBEEF);
      vec_cnt++; if (r_strobes !== 3) begin err_cnt++; $display("FAIL core_read strobes: got %0d want 3", r_strobes); end
      vec_cnt++; if (r_addr !== 32'h100 || r_size !== 3'b010) begin err_cnt++; $display("FAIL core_read addr/size: got %h/%0d want 100/2", r_addr, r_size); end
      vec_cnt++; if (r_lat !== 4 || r_who !== 0) begin err_cnt++; $display("FAIL core_read done: lat %0d who %0d want 4 core", r_lat, r_who); end
      vec_cnt++; if (r_rdata !== 32'hDEADBEEF || r_fault !== 0) begin err_cnt++; $display("FAIL core_read data: got %h/%0d want deadbeef/0", r_rdata, r_fault); end
      vec_cnt++; if (r_other_bad || r_pulse_bad || r_own1) begin err_cnt++; $display("FAIL core_read side: other %0d pulse %0d own %0d want 0 0 0", r_other_bad, r_pulse_bad, r_own1); end
   endtask

   task automatic test_bus_error();
      set_dbg(0, 1, 32'h2000, 32'h55, 3'b010);
      run(0, 1, 32'h12345678);
      vec_cnt++; if (r_who !== 1 || r_own1 !== 1) begin err_cnt++; $display("FAIL err owner: who %0d own %0d want 1 1", r_who, r_own1); end
      vec_cnt++; if (r_addr !== 32'h2000 || r_wdata !== 32'h55) begin err_cnt++; $display("FAIL err cmd: got %h/%h want 2000/55", r_addr, r_wdata); end
      vec_cnt++; if (r_strobes !== 1 || r_lat !== 2) begin err_cnt++; $display("FAIL err timing: strobes %0d lat %0d want 1 2", r_strobes, r_lat); end
      vec_cnt++; if (r_fault !== 1 || r_rdata !== 0 || r_other_bad) begin err_cnt++; $display("FAIL err resp: fault %0d rdata %h other %0d want 1 0 0", r_fault, r_rdata, r_other_bad); end
   endtask

   task automatic test_timeout();
      set_core(1, 0, 32'h300, 0, 3'b010);
      run(0, 0, 0);
      vec_cnt++; if (r_strobes !== 4 || r_lat !== 5) begin err_cnt++; $display("FAIL timeout timing: strobes %0d lat %0d want 4 5", r_strobes, r_lat); end
      vec_cnt++; if (r_fault !== 1 || r_rdata !== 0) begin err_cnt++; $display("FAIL timeout resp: fault %0d rdata %h want 1 0", r_fault, r_rdata); end
      set_core(1, 0, 32'h304, 0, 3'b010);
      run(4, 0, 32'hCAFEF00D);
      vec_cnt++; if (r_fault !== 0 || r_rdata !== 32'hCAFEF00D || r_lat !== 5) begin err_cnt++; $display("FAIL ack_on_timeout: fault %0d rdata %h lat %0d want 0 cafef00d 5", r_fault, r_rdata, r_lat); end
   endtask

   task automatic test_write_ack();
      set_dbg(0, 1, 32'h2004, 32'hA5A5A5A5, 3'b001);
      run(2, 0, 32'hFFFFFFFF);
      vec_cnt++; if (r_rdata !== 0 || r_fault !== 0 || r_lat !== 3) begin err_cnt++; $display("FAIL write_ack: rdata %h fault %0d lat %0d want 0 0 3", r_rdata, r_fault, r_lat); end
      set_dbg(1, 0, 32'h2008, 0, 3'b010);
      run(1, 1, 32'h11112222);
      vec_cnt++; if (r_fault !== 1 || r_rdata !== 0) begin err_cnt++; $display("FAIL err_beats_ack: fault %0d rdata %h want 1 0", r_fault, r_rdata); end
   endtask

   task automatic test_illegal();
      set_core(1, 1, 32'h400, 32'h9, 3'b010);
      run(1, 0, 32'h77);
      vec_cnt++; if (r_strobes !== 0 || r_lat !== 2 || r_fault !== 1) begin err_cnt++; $display("FAIL illegal: strobes %0d lat %0d fault %0d want 0 2 1", r_strobes, r_lat, r_fault); end
   endtask

   task automatic test_tie();
      rst = 1; tick(); rst = 0;
      set_core(1, 0, 32'h10, 0, 3'b010);
      set_dbg(1, 0, 32'h20, 0, 3'b010);
      run(1, 0, 32'hA1);
      vec_cnt++; if (r_who !== 0 || r_own1 !== 0 || r_addr !== 32'h10) begin err_cnt++; $display("FAIL tie1: who %0d own %0d addr %h want core 0 10", r_who, r_own1, r_addr); end
      run(1, 0, 32'hB2);
      vec_cnt++; if (r_who !== 1 || r_own1 !== 1 || r_rdata !== 32'hB2) begin err_cnt++; $display("FAIL tie2: who %0d own %0d rdata %h want dbg 1 b2", r_who, r_own1, r_rdata); end
      set_core(1, 0, 32'h14, 0, 3'b010);
      set_dbg(1, 0, 32'h24, 0, 3'b010);
      run(1, 0, 32'hC3);
      vec_cnt++; if (r_who !== 0) begin err_cnt++; $display("FAIL tie3: who %0d want core", r_who); end
      set_core(1, 0, 32'h18, 0, 3'b010);
      run(1, 0, 32'hD4);
      vec_cnt++; if (r_who !== 1 || r_addr !== 32'h24) begin err_cnt++; $display("FAIL tie4: who %0d addr %h want dbg 24", r_who, r_addr); end
      run(1, 0, 32'hE5);
      vec_cnt++; if (r_who !== 0 || r_addr !== 32'h18) begin err_cnt++; $display("FAIL tie5: who %0d addr %h want core 18", r_who, r_addr); end
   endtask

   task automatic test_reset_mid_busy();
      set_core(1, 0, 32'h40, 0, 3'b010);
      tick();
      tick();
      vec_cnt++; if (bus_rd !== 1) begin err_cnt++; $display("FAIL pre_reset busy: bus_rd %0d want 1", bus_rd); end
      rst = 1;
      set_dbg(1, 0, 32'h50, 0, 3'b010);
      #1;
      vec_cnt++;
      if ({bus_rd, bus_wr, bus_addr, core_done, dbg_done, owner_dbg} !== '0) begin
         err_cnt++; $display("FAIL async_reset: bus_rd %0d bus_addr %h owner %0d want 0", bus_rd, bus_addr, owner_dbg);
      end
      tick();
      vec_cnt++; if (core_done !== 0 || dbg_done !== 0) begin err_cnt++; $display("FAIL reset_no_done: core %0d dbg %0d want 0 0", core_done, dbg_done); end
      rst = 0;
      run(1, 0, 32'h0F0F0F0F);
      vec_cnt++; if (r_who !== 0 || r_addr !== 32'h40) begin err_cnt++; $display("FAIL post_reset tie: who %0d addr %h want core 40", r_who, r_addr); end
      run(1, 0, 32'h1);
      vec_cnt++; if (r_who !== 1 || r_addr !== 32'h50) begin err_cnt++; $display("FAIL post_reset dbg: who %0d addr %h want dbg 50", r_who, r_addr); end
   endtask

   initial begin
      test_reset();
      test_core_read();
      test_bus_error();
      test_timeout();
      test_write_ack();
      test_illegal();
      test_tie();
      test_reset_mid_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter sharing the single system bus master port between the core memory interface (instruction fetch and load/store) and the debug module's system-bus access path.
- Grants the bus to one requester per transaction and latches that requester's command.
- Drives the bus until acknowledge, error or timeout, then returns a one-cycle registered response to the owner.
- Sits between the requesters and the bus fabric; neither requester sees the other's traffic.

Parameters:
AddrWidth, 32, bus address width
DataWidth, 32, bus data width
TimeoutCycles, 255, maximum BUSY cycles without ack/err before the arbiter aborts with fault (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
core_rd  in  1  core read request
core_wr  in  1  core write request
core_addr  in  AddrWidth  core address
core_wdata  in  DataWidth  core write data
core_size  in  3  core funct3-style sign/size code
core_rdata  out  DataWidth  read data to core, valid with core_done
core_done  out  1  one-cycle completion pulse to core
core_fault  out  1  fault flag, valid with core_done
dbg_rd, dbg_wr, dbg_addr, dbg_wdata, dbg_size  in  same widths as core_*  debug requester command
dbg_rdata, dbg_done, dbg_fault  out  same widths as core_*  debug requester response
bus_rd  out  1  bus read strobe
bus_wr  out  1  bus write strobe
bus_addr  out  AddrWidth  bus address
bus_wdata  out  DataWidth  bus write data
bus_size  out  3  bus size code
bus_rdata  in  DataWidth  bus read data, valid with bus_ack
bus_ack  in  1  bus transfer complete
bus_err  in  1  bus transfer error
owner_dbg  out  1  1 while debug owns the bus (BUSY/RESP), else 0

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, last-grant pointer = debug (core wins the first tie), timeout counter 0. Asserting rst mid-transaction aborts it silently; no done pulse is issued.
- A request is active when rd|wr is 1. The requester holds the command stable until its done pulse and drops it in the done cycle.
- States:
  - IDLE: if exactly one requester is active, grant it. If both are active, grant the one not in the last-grant pointer (round-robin). Latch the owner's rd/wr/addr/wdata/size into registers, update the pointer, go to BUSY. No active request: stay.
  - BUSY: bus_* outputs driven from the latched registers. rd&wr both latched is illegal: go directly to RESP with fault=1, no bus strobe. Otherwise count cycles:
    - bus_err -> RESP, fault=1, rdata=0.
    - else bus_ack -> RESP, fault=0, capture bus_rdata (writes return 0).
    - else counter reaches TimeoutCycles -> RESP, fault=1, rdata=0.
  - RESP: bus strobes 0. Owner's done=1 for exactly one cycle with registered rdata/fault. Non-owner outputs stay 0. Go to IDLE. Requests are not sampled in this cycle.
- Bus strobes drop in the cycle after ack/err (registered outputs).
- Latency: request seen in IDLE at cycle 0; bus strobe at cycle 1; ack at cycle k gives done at k+1; next grant decided at k+2.
- Simultaneous events:
  - err and ack together: err wins.
  - ack on the timeout cycle: ack wins.
  - A new request from the owner during RESP is ignored until IDLE.
- Timeout counter resets to 0 on entry to BUSY and is sized to hold TimeoutCycles.
- rdata/fault outputs hold their last value when done=0 is acceptable only for the owner. Non-owner rdata/fault must read 0.

Test Plan:
- Core read alone: core_rd=1, addr 0x100, bus_ack on 3rd BUSY cycle with rdata 0xDEADBEEF -> bus_rd=1 for 3 cycles, addr 0x100, core_done one cycle later with rdata 0xDEADBEEF, fault 0; dbg_done stays 0.
- Tie after reset: core and debug both request in the same cycle -> core granted first, owner_dbg=0. After core_done, debug granted, owner_dbg=1. Repeating the tie alternates grants.
- Bus error: dbg_wr to 0x2000 with wdata 0x55, bus_err=1 on 1st BUSY cycle -> dbg_done=1, dbg_fault=1, dbg_rdata=0; bus_wr deasserted the next cycle.
- Timeout: TimeoutCycles=4, no ack -> bus_rd high exactly 4 cycles, then core_done with fault=1. Ack arriving on the 4th cycle instead -> fault=0 with data.
- Illegal command: core_rd=core_wr=1 -> no bus strobe, core_done with fault=1 two cycles after the request.
- Reset mid-BUSY: rst pulsed on 2nd BUSY cycle -> all outputs 0 immediately, no done pulse; after release, a pending debug+core tie grants core.
